// File: rtl/temp_bcd_encoder_pkg.sv
// Shared constants and FSM encoding for the averaging temperature-to-BCD encoder.
package temp_pkg;
  typedef enum logic [1:0] {COLLECT, LOAD, CONVERT, PUBLISH} state_e;

  localparam int DATA_W       = 10;
  localparam int BCD_W        = 4;
  localparam int NDIG         = 3;
  localparam int ITERS        = 10;
  localparam int ITER_W       = 4;
  localparam int MAX_TEMP_DEF = 399;
endpackage

// File: rtl/temp_bcd_encoder_if.sv
// Sample handshake and display bus between producer, encoder and display.
interface temp_bcd_encoder_if;
  import temp_pkg::*;
  logic              SAMPLE_VALID;
  logic [DATA_W-1:0] SAMPLE_F;
  logic              SAMPLE_READY;
  logic [DATA_W-1:0] TEMP_F;
  logic              TEMP_UPDATE;
  logic              TEMP_OVERRANGE;

  modport master (output SAMPLE_VALID, SAMPLE_F,
                  input  SAMPLE_READY, TEMP_F, TEMP_UPDATE, TEMP_OVERRANGE);
  modport slave  (input  SAMPLE_VALID, SAMPLE_F,
                  output SAMPLE_READY, TEMP_F, TEMP_UPDATE, TEMP_OVERRANGE);
endinterface

// File: rtl/temp_bcd_encoder_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import temp_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);
  assign d_o = (d_i >= BCD_W'(5)) ? d_i + BCD_W'(3) : d_i;
endmodule

// File: rtl/temp_bcd_encoder.sv
// Averages 2^AVG_LOG2 samples, saturates to MAX_TEMP, converts to packed BCD
// with a serial double-dabble and publishes with a one-cycle update pulse.
module temp_bcd_encoder
  import temp_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_TEMP = MAX_TEMP_DEF
) (
  input logic                CLOCK_50,
  input logic                RESET_N,
  temp_bcd_encoder_if.slave  bus
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SH_W  = NDIG*BCD_W + DATA_W;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DATA_W-1:0] MAX_V    = DATA_W'(MAX_TEMP);

  state_e                        state_q, state_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ITER_W-1:0]             it_q, it_d;
  logic [NDIG-1:0][BCD_W-1:0]    bcd_q, bcd_d, bcd_cor;
  logic [DATA_W-1:0]             bin_q, bin_d;
  logic                          ovr_q, ovr_d;
  logic [DATA_W-1:0]             temp_q, temp_d;
  logic                          tovr_q, tovr_d;
  logic                          upd_q, upd_d;
  logic [DATA_W-1:0]             avg;
  logic [SH_W-1:0]               sh;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_add3 u_add3 (.d_i(bcd_q[g]), .d_o(bcd_cor[g]));
  end

  assign avg              = DATA_W'(acc_q >> AVG_LOG2);
  assign bus.SAMPLE_READY = (state_q == COLLECT);
  assign bus.TEMP_F       = temp_q;
  assign bus.TEMP_UPDATE  = upd_q;
  assign bus.TEMP_OVERRANGE = tovr_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    it_d    = it_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    ovr_d   = ovr_q;
    temp_d  = temp_q;
    tovr_d  = tovr_q;
    upd_d   = 1'b0;
    sh      = {bcd_cor, bin_q};
    unique case (state_q)
      COLLECT: if (bus.SAMPLE_VALID) begin
        acc_d = acc_q + ACC_W'(bus.SAMPLE_F);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = LOAD;
      end
      LOAD: begin
        if (avg > MAX_V) begin
          bin_d = MAX_V;
          ovr_d = 1'b1;
        end else begin
          bin_d = avg;
          ovr_d = 1'b0;
        end
        bcd_d   = '0;
        it_d    = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        // Correct digits of the current partial result, then shift in the next MSB.
        {bcd_d, bin_d} = sh << 1;
        it_d = it_q + ITER_W'(1);
        if (it_q == ITER_W'(ITERS-1)) state_d = PUBLISH;
      end
      PUBLISH: begin
        temp_d  = {bcd_q[2][1:0], bcd_q[1], bcd_q[0]};
        tovr_d  = ovr_q;
        upd_d   = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
      it_q    <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      ovr_q   <= 1'b0;
      temp_q  <= '0;
      tovr_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      it_q    <= it_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      ovr_q   <= ovr_d;
      temp_q  <= temp_d;
      tovr_q  <= tovr_d;
      upd_q   <= upd_d;
    end
  end
endmodule

// File: tb/tb_temp_bcd_encoder.sv
// Scoreboard bench: one encoder with no averaging, one averaging four samples.
module tb_temp_bcd_encoder;
  logic clk = 1'b0;
  logic RESET_N = 1'b0;
  always #10 clk = ~clk;

  temp_bcd_encoder_if if0 ();
  temp_bcd_encoder_if if2 ();

  temp_bcd_encoder #(.AVG_LOG2(0), .MAX_TEMP(399)) dut0 (.CLOCK_50(clk), .RESET_N(RESET_N), .bus(if0));
  temp_bcd_encoder #(.AVG_LOG2(2), .MAX_TEMP(399)) dut2 (.CLOCK_50(clk), .RESET_N(RESET_N), .bus(if2));

  typedef struct { logic [9:0] f; logic o; } exp_t;
  exp_t exp0[$];
  exp_t exp2[$];
  int   grp2[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [9:0] last0 = '0, last2 = '0;

  function automatic void chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: saturate, then decimal digits by plain division.
  function automatic exp_t ref_enc(int avg);
    exp_t e;
    int s;
    s = (avg > 399) ? 399 : avg;
    e.o = (avg > 399);
    e.f = 10'(((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10));
    return e;
  endfunction

  function automatic void model(bit w, int d);
    int sum;
    if (!w) exp0.push_back(ref_enc(d));
    else begin
      grp2.push_back(d);
      if (grp2.size() == 4) begin
        sum = 0;
        foreach (grp2[i]) sum += grp2[i];
        exp2.push_back(ref_enc(sum / 4));
        grp2.delete();
      end
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input bit w, input int d, input bit push);
    int g;
    if (w) begin if2.SAMPLE_VALID = 1'b1; if2.SAMPLE_F = 10'(d); end
    else   begin if0.SAMPLE_VALID = 1'b1; if0.SAMPLE_F = 10'(d); end
    g = 0;
    while (!(w ? if2.SAMPLE_READY : if0.SAMPLE_READY) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (push) model(w, d);
    if (w) if2.SAMPLE_VALID = 1'b0; else if0.SAMPLE_VALID = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp0.size() != 0 || exp2.size() != 0) && g < 400) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 400) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!RESET_N) begin last0 = '0; last2 = '0; end
    else begin
      if (if0.TEMP_UPDATE) begin
        if (exp0.size() == 0) chk("upd0_unexpected", 1, 0);
        else begin
          e = exp0.pop_front();
          chk("temp0", int'(if0.TEMP_F), int'(e.f));
          chk("ovr0", int'(if0.TEMP_OVERRANGE), int'(e.o));
        end
        chk("digits0", int'(if0.TEMP_F[7:4] <= 9 && if0.TEMP_F[3:0] <= 9), 1);
        last0 = if0.TEMP_F;
      end else chk("hold0", int'(if0.TEMP_F), int'(last0));
      if (if2.TEMP_UPDATE) begin
        if (exp2.size() == 0) chk("upd2_unexpected", 1, 0);
        else begin
          e = exp2.pop_front();
          chk("temp2", int'(if2.TEMP_F), int'(e.f));
          chk("ovr2", int'(if2.TEMP_OVERRANGE), int'(e.o));
        end
        last2 = if2.TEMP_F;
      end else chk("hold2", int'(if2.TEMP_F), int'(last2));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lo, base;
    if0.SAMPLE_VALID = 1'b0; if0.SAMPLE_F = '0;
    if2.SAMPLE_VALID = 1'b0; if2.SAMPLE_F = '0;
    #35;
    chk("rst_temp0", int'(if0.TEMP_F), 0);
    chk("rst_upd0", int'(if0.TEMP_UPDATE), 0);
    chk("rst_ovr0", int'(if0.TEMP_OVERRANGE), 0);
    chk("rst_temp2", int'(if2.TEMP_F), 0);
    chk("rst_ready2", int'(if2.SAMPLE_READY), 1);
    @(negedge clk); RESET_N = 1'b1;
    @(posedge clk); #1;

    // Single sample, fixed latency of 12 edges to the update cycle.
    send(0, 72, 1);
    lat = 0;
    while (!if0.TEMP_UPDATE && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("latency0", lat, 12);
    drain();

    // Saturation boundaries.
    send(0, 399, 1); send(0, 400, 1); send(0, 1023, 1); send(0, 0, 1);
    drain();

    // Full legal range sweep, back-to-back with valid held.
    for (int v = 0; v <= 399; v++) send(0, v, 1);
    for (int i = 0; i < 20; i++) send(0, int'($urandom_range(0, 1023)), 1);
    drain();

    // Four-sample average and the not-ready window after the last sample.
    send(1, 70, 1); send(1, 71, 1); send(1, 72, 1); send(1, 73, 1);
    lo = 0;
    while (!if2.SAMPLE_READY && lo < 30) begin lo++; @(posedge clk); #1; end
    chk("ready_low2", lo, 12);
    drain();

    // Valid held with incrementing data: any extra acceptance corrupts the averages.
    base = int'($urandom_range(0, 900));
    for (int i = 0; i < 40; i++) send(1, base + i, 1);
    for (int i = 0; i < 40; i++) send(1, int'($urandom_range(0, 1023)), 1);
    drain();

    // Reset during the 5th CONVERT cycle aborts without an update.
    send(0, 72, 1);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("pre_rst_temp0", int'(if0.TEMP_F), 'h072);
    send(0, 123, 0);
    repeat (5) @(posedge clk);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_temp0", int'(if0.TEMP_F), 0);
    chk("abort_upd0", int'(if0.TEMP_UPDATE), 0);
    @(negedge clk); @(negedge clk); RESET_N = 1'b1;
    #1;
    chk("abort_ready0", int'(if0.SAMPLE_READY), 1);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_noupd_q", exp0.size(), 0);

    // Post-reset operation still correct.
    send(0, 305, 1);
    drain();
    chk("final_q2", exp2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/temp_bcd_encoder.md
TEMP_BCD_ENCODER -- requirements
Module: temp_bcd_encoder

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 2: number of samples averaged per update is 2^AVG_LOG2; legal range 0..4.
REQ-002 The block SHALL have parameter MAX_TEMP, default 399: saturation ceiling in degF; legal range 0..399.
REQ-003 The block SHALL have port CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port SAMPLE_VALID  input  1  the producer offers SAMPLE_F this cycle.
REQ-006 The block SHALL have port SAMPLE_F  input  10  unsigned binary temperature in degF.
REQ-007 The block SHALL have port SAMPLE_READY  output  1  the block can accept a sample this cycle.
REQ-008 The block SHALL have port TEMP_F  output  10  packed BCD for the display: [9:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 The block SHALL have port TEMP_UPDATE  output  1  one-cycle pulse when TEMP_F takes a new value.
REQ-010 The block SHALL have port TEMP_OVERRANGE  output  1  the published value was saturated to MAX_TEMP.

Function
REQ-011 A sample SHALL be accepted on a rising edge where SAMPLE_VALID and SAMPLE_READY are both 1; no other edge accepts a sample.
REQ-012 The FSM SHALL have states COLLECT, LOAD, CONVERT and PUBLISH; SAMPLE_READY SHALL be 1 only in COLLECT and SHALL decode from state alone.
REQ-013 In COLLECT, each accepted sample SHALL be added to an accumulator of width 10+AVG_LOG2 without overflow, and the sample counter SHALL increment.
REQ-014 The handshake edge of sample number 2^AVG_LOG2 SHALL move the FSM to LOAD.
REQ-015 In LOAD, average = accumulator >> AVG_LOG2 (truncating); if average > MAX_TEMP the value SHALL be MAX_TEMP and the overrange flag 1, otherwise the value SHALL be the average and the flag 0.
REQ-016 CONVERT SHALL run double-dabble for exactly 10 cycles, one bit per cycle, MSB first: add 3 to each BCD digit >= 5, then shift left one bit.
REQ-017 The edge after the 10th shift SHALL load TEMP_F and TEMP_OVERRANGE, set TEMP_UPDATE to 1 for exactly one cycle, clear the accumulator and counter, and return the FSM to COLLECT.
REQ-018 Latency SHALL be fixed: TEMP_UPDATE SHALL be high in the cycle following edge N+12, where edge N accepted the final sample.
REQ-019 TEMP_F and TEMP_OVERRANGE SHALL hold their values between updates.
REQ-020 SAMPLE_VALID held high while SAMPLE_READY=0 SHALL be ignored, with no sample lost or duplicated; a held sample SHALL be accepted on the first COLLECT edge.
REQ-021 With AVG_LOG2=0, every accepted sample SHALL produce one update.

Reset
REQ-022 While RESET_N=0 the block SHALL immediately force: FSM to COLLECT, accumulator and counter to 0, TEMP_F to 10'h000, TEMP_UPDATE to 0 and TEMP_OVERRANGE to 0.
REQ-023 Reset asserted mid-collection or mid-conversion SHALL abort the operation without emitting a TEMP_UPDATE pulse; SAMPLE_READY SHALL be 1 in the first cycle after RESET_N is released.

Structure
REQ-024 Package temp_pkg SHALL hold the FSM state encoding, the BCD digit width (4), the iteration count (10) and the MAX_TEMP default.
REQ-025 The per-digit add-3 correction SHALL be one combinational sub-module, bcd_add3, instantiated once per digit (3 instances).

Verification
REQ-026 With AVG_LOG2=0, SAMPLE_F=72 -> TEMP_F=10'h072, TEMP_OVERRANGE=0, TEMP_UPDATE pulse at handshake edge + 12.
REQ-027 With AVG_LOG2=2, back-to-back samples 70, 71, 72, 73 -> sum 286, TEMP_F=10'h071, SAMPLE_READY=0 for 12 cycles after the 4th sample.
REQ-028 With AVG_LOG2=0, the sequence 399, 400, 1023, 0 -> TEMP_F = 0x399, 0x399, 0x399, 0x000 with TEMP_OVERRANGE = 0, 1, 1, 0.
REQ-029 SAMPLE_VALID held high continuously with incrementing data -> exactly one sample accepted per COLLECT cycle and no acceptance during LOAD, CONVERT or PUBLISH; the scoreboard SHALL match every update.
REQ-030 RESET_N pulsed low during the 5th CONVERT cycle after TEMP_F=0x072 -> TEMP_F=0x000 immediately, no TEMP_UPDATE pulse, SAMPLE_READY=1 after release.
REQ-031 All values 0..MAX_TEMP swept at AVG_LOG2=0 -> every TEMP_F equals the reference BCD encoding and no digit exceeds 9.
